// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_pkg
// Purpose  : Shared segment encodings and FSM state type for seg_display_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low, bit 0 = segment a, bit 6 = segment g
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg_display_ctrl_enc.sv
`default_nettype none
// ============================================================================
// Module   : seg_digit_enc
// Purpose  : One BCD digit to an active-low seven-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seg_digit_enc
    import seg_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_ctrl
// Purpose  : Multi-field binary to decimal seven-segment controller using one
//            shared sequential double-dabble engine. Optional blinking is
//            enabled by defining SEG_DISPLAY_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int IN_W       = 8,
    parameter int DIGITS     = 2,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [NUM_FIELDS*IN_W-1:0]     value,
    input  logic [NUM_FIELDS-1:0]          blink_mask,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_FIELDS*DIGITS*7-1:0] hex
);

    localparam int          c_fw      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int          c_cw      = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int          c_bw      = 4 * DIGITS;
    localparam int unsigned c_max_val = 10**DIGITS - 1;

    state_t                         r_state;
    logic [c_fw-1:0]                r_field;
    logic [c_cw-1:0]                r_cnt;
    logic [NUM_FIELDS*IN_W-1:0]     r_shadow;
    logic [IN_W-1:0]                r_bin;
    logic [c_bw-1:0]                r_bcd;
    logic [NUM_FIELDS-1:0]          r_ovf;
    logic [NUM_FIELDS*DIGITS*7-1:0] r_hex;
    logic                           r_busy;
    logic                           r_done;

    logic [c_fw-1:0]                w_field_next;
    logic [IN_W-1:0]                w_next_bin;
    logic                           w_ovf_first;
    logic                           w_ovf_next;
    logic [c_bw-1:0]                w_bcd_adj;
    logic [DIGITS*7-1:0]            w_field_seg;
    logic                           w_unused_carry;

    assign w_field_next   = r_field + 1'b1;
    assign w_next_bin     = r_shadow[w_field_next*IN_W +: IN_W];
    assign w_ovf_first    = 32'(value[IN_W-1:0]) > c_max_val;
    assign w_ovf_next     = 32'(w_next_bin) > c_max_val;
    // Top adjusted bit is shifted out; an overflowing field shows dashes anyway
    assign w_unused_carry = w_bcd_adj[c_bw-1];

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        assign w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3
                                                                 : r_bcd[4*d +: 4];
        seg_digit_enc u_enc (
            .digit (r_bcd[4*d +: 4]),
            .seg   (w_field_seg[7*d +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_field  <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_ovf    <= '0;
            r_hex    <= {(NUM_FIELDS*DIGITS){SEG_BLANK}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shadow <= value;
                        r_field  <= '0;
                        r_bin    <= value[IN_W-1:0];
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_ovf    <= '0;
                        r_ovf[0] <= w_ovf_first;
                        r_busy   <= 1'b1;
                        r_state  <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= {w_bcd_adj[c_bw-2:0], r_bin[IN_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cw'(IN_W - 1)) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_hex[r_field*DIGITS*7 +: DIGITS*7] <= r_ovf[r_field] ? {DIGITS{SEG_DASH}}
                                                                          : w_field_seg;
                    if (r_field == c_fw'(NUM_FIELDS - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_field             <= w_field_next;
                        r_bin               <= w_next_bin;
                        r_bcd               <= '0;
                        r_cnt               <= '0;
                        r_ovf[w_field_next] <= w_ovf_next;
                        r_state             <= CONV;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

`ifdef SEG_DISPLAY_BLINK_EN
    localparam int c_blw = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [c_blw-1:0] r_blink_cnt;
    logic             r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == c_blw'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_blink
        assign hex[i*DIGITS*7 +: DIGITS*7] = (blink_mask[i] && !r_phase)
                                           ? {DIGITS{SEG_BLANK}}
                                           : r_hex[i*DIGITS*7 +: DIGITS*7];
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign hex            = r_hex;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_ctrl
// Purpose  : Directed vector bench for seg_display_ctrl (default parameters,
//            BLINK_DIV=4; blink expectations follow SEG_DISPLAY_BLINK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

`ifdef SEG_DISPLAY_BLINK_EN
    localparam bit c_blink = 1'b1;
`else
    localparam bit c_blink = 1'b0;
`endif

    localparam logic [6:0]  c_blank = 7'h7F;
    localparam logic [6:0]  c_dash  = 7'b0111111;
    localparam logic [41:0] c_all_blank = {6{7'h7F}};

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [23:0] value;
    logic [2:0]  blink_mask;
    logic        busy;
    logic        done;
    logic [41:0] hex;

    int checks = 0;
    int errors = 0;
    int tb_edges;

    logic [6:0] seg_tab [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        logic [23:0]     value;
        logic [23:0]     value2;
        int              load2_cycle;
        logic [2:0][7:0] exp;   // per field: BCD tens/units, 8'hFF = dashes
    } vec_t;

    vec_t vecs [5];

    seg_display_ctrl #(
        .NUM_FIELDS (3),
        .IN_W       (8),
        .DIGITS     (2),
        .BLINK_DIV  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blink_mask (blink_mask),
        .busy       (busy),
        .done       (done),
        .hex        (hex)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_edges <= 0;
        else     tb_edges <= tb_edges + 1;
    end

    function automatic logic [13:0] field_pat(input logic [7:0] code);
        logic [3:0] tens;
        logic [3:0] units;
        if (code == 8'hFF) return {c_dash, c_dash};
        tens  = code[7:4];
        units = code[3:0];
        return {seg_tab[tens], seg_tab[units]};
    endfunction

    function automatic logic [41:0] exp_hex(input logic [2:0][7:0] e);
        return {field_pat(e[2]), field_pat(e[1]), field_pat(e[0])};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic run_conv(input logic [23:0] v, input logic [23:0] v2, input int c2,
                            output int first_done, output int n_done,
                            output logic busy1, output logic busy28);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(posedge clk);
        first_done = -1;
        n_done     = 0;
        busy1      = 1'b0;
        busy28     = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (c == 1)  busy1  = busy;
            if (c == 28) busy28 = busy;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            load = (c == c2);
            if (c == c2) value = v2;
            @(posedge clk);
        end
        #1;
        load = 1'b0;
    endtask

    initial begin
        int          fd;
        int          nd;
        logic        b1;
        logic        b28;
        logic [41:0] old_hex;
        logic [41:0] exp_v;

        vecs[0] = '{{8'd56, 8'd34, 8'd12},  24'd0, 0, {8'h56, 8'h34, 8'h12}};
        vecs[1] = '{{8'd0, 8'd99, 8'd100},  24'd0, 0, {8'h00, 8'h99, 8'hFF}};
        vecs[2] = '{{8'd10, 8'd9, 8'd255},  24'd0, 0, {8'h10, 8'h09, 8'hFF}};
        vecs[3] = '{{8'd7, 8'd200, 8'd45}, {8'd1, 8'd2, 8'd3}, 5, {8'h07, 8'hFF, 8'h45}};
        vecs[4] = '{{8'd1, 8'd98, 8'd255},  24'd0, 0, {8'h01, 8'h98, 8'hFF}};

        rst        = 1'b1;
        load       = 1'b0;
        value      = '0;
        blink_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hex",  64'(hex),  64'(c_all_blank));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("post_reset_idle", 64'({hex, busy, done}), 64'({c_all_blank, 2'b00}));
        end

        for (int v = 0; v < 5; v++) begin
            run_conv(vecs[v].value, vecs[v].value2, vecs[v].load2_cycle, fd, nd, b1, b28);
            check($sformatf("v%0d_done_cycle", v), 64'(fd), 64'd28);
            check($sformatf("v%0d_done_count", v), 64'(nd), 64'd1);
            check($sformatf("v%0d_busy_c1", v),    64'(b1), 64'd1);
            check($sformatf("v%0d_busy_c28", v),   64'(b28), 64'd0);
            check($sformatf("v%0d_hex", v),        64'(hex), 64'(exp_hex(vecs[v].exp)));
        end

        // Partial update then asynchronous reset mid-conversion
        old_hex = exp_hex(vecs[4].exp);
        @(negedge clk);
        value = {8'd56, 8'd34, 8'd12};
        load  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            #1;
            load = 1'b0;
            if (c == 9)  check("partial_c9",  64'(hex), 64'(old_hex));
            if (c == 10) check("partial_c10", 64'(hex), 64'({old_hex[41:14], field_pat(8'h12)}));
            if (c == 12) begin
                check("partial_busy_c12", 64'(busy), 64'd1);
                rst = 1'b1;
                #1;
                check("midrst_hex",  64'(hex),  64'(c_all_blank));
                check("midrst_busy", 64'(busy), 64'd0);
                check("midrst_done", 64'(done), 64'd0);
            end else begin
                @(posedge clk);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        run_conv(vecs[0].value, 24'd0, 0, fd, nd, b1, b28);
        check("after_rst_done_cycle", 64'(fd),  64'd28);
        check("after_rst_hex",        64'(hex), 64'(exp_hex(vecs[0].exp)));

        // Blinking of field 1 only
        exp_v = exp_hex(vecs[0].exp);
        @(negedge clk);
        blink_mask = 3'b010;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (c_blink && (((tb_edges / 4) % 2) == 1))
                check("blink_hex", 64'(hex), 64'({exp_v[41:28], c_blank, c_blank, exp_v[13:0]}));
            else
                check("blink_hex", 64'(hex), 64'(exp_v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised multi-field decimal display controller for the seven-segment bank. It accepts NUM_FIELDS binary values and converts each to DIGITS decimal digits with a single shared sequential double-dabble engine, processing one field at a time. Results are held in registered active-low segment outputs, with optional per-field blinking. It replaces the fixed three-field combinational display path in the traffic-light and clock tops.

## Interface
- NUM_FIELDS, 3: number of independent binary fields.
- IN_W, 8: width of each binary field.
- DIGITS, 2: decimal digits shown per field.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period; must be ≥ 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle request to capture `value`; honoured only when busy=0.
- value  in  NUM_FIELDS*IN_W  field i at [i*IN_W +: IN_W].
- blink_mask  in  NUM_FIELDS  bit i=1 blinks field i.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when all fields have been committed.
- hex  out  NUM_FIELDS*DIGITS*7  active-low segments; field i, digit j (j=0 is least significant) at [(i*DIGITS+j)*7 +: 7]; bit 0 = segment a, bit 6 = segment g.

## Operation
- FSM states: IDLE, CONV, COMMIT, DONE.
- IDLE: on load=1, capture all of `value` into a shadow register, set field index f=0, and go to CONV. busy=1 from the next cycle.
- CONV: runs IN_W cycles on field f. Each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1. The BCD register is 4*DIGITS wide.
- Overflow: at CONV entry, if field f > 10**DIGITS−1, a sticky ovf flag is set for that field.
- COMMIT: writes the segment patterns for field f into the hex register. An overflowed field gets SEG_DASH (7'b0111111) on all of its digits. If f<NUM_FIELDS−1, increment f and return to CONV; otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- load while busy=1 is ignored. There is no queue and no error flag.
- Fields not yet committed keep their previous patterns, so the display updates field by field.
- Leading zeros are shown, not blanked.
- Blink: the phase toggles every BLINK_DIV cycles. While phase=0, any field with its blink_mask bit set drives 7'h7F. This masking is applied at the output, after the hex register, so the stored value is never altered.

## Timing
- Reset values: hex all 7'h7F (blank), busy=0, done=0, FSM=IDLE, blink counter=0, phase=1 (visible).
- Latency: load at cycle 0 → done high at cycle NUM_FIELDS*(IN_W+1)+1. This is 28 cycles for the defaults.
- Field i is visible from cycle (i+1)*(IN_W+1)+1.
- rst mid-conversion: takes effect immediately. All outputs return to their reset values and the partial result is discarded.
- blink_mask is sampled combinationally, so a change applies in the same cycle.
- The blink counter runs regardless of FSM state.

## Configuration
- SEG_DISPLAY_BLINK_EN defined: the blink counter, phase register and output masking are present.
- SEG_DISPLAY_BLINK_EN undefined: blink_mask is ignored (the port remains), no counter is synthesised, and hex drives the register directly.

## Structure
- Package seg_display_pkg holds:
  - SEG_DIGIT[0:9] active-low encodings, with '0'=7'b1000000, '1'=7'b1111001, '2'=7'b0100100, '3'=7'b0110000, '4'=7'b0011001, '5'=7'b0010010, '6'=7'b0000010, '7'=7'b1111000, '8'=7'b0000000, '9'=7'b0010000.
  - SEG_BLANK=7'h7F and SEG_DASH=7'b0111111.
  - The FSM state enum.
- One sub-module, seg_digit_enc: combinational 4-bit digit → 7-bit pattern, instantiated DIGITS times on the BCD register.

## Test plan
- Reset: assert rst → hex all 7'h7F, busy=0, done=0; release → stays blank, no done.
- Defaults, value={8'd56,8'd34,8'd12}, load pulse → done at cycle 28; field 0 = {'1','2'}, field 1 = {'3','4'}, field 2 = {'5','6'} using the SEG_DIGIT encodings; busy=0 after done.
- Overflow: field 0=100, field 1=99, field 2=0 → field 0 is two SEG_DASH, field 1 is '9','9', field 2 is '0','0'.
- Second load at cycle 5 with different data → ignored; the result matches the first load and exactly one done pulse occurs.
- rst asserted at cycle 12 of a conversion → hex 7'h7F and busy=0 immediately; a later load converts correctly.
- SEG_DISPLAY_BLINK_EN, BLINK_DIV=4, blink_mask=3'b010 → field 1 alternates between its digits and 7'h7F every 4 cycles; fields 0 and 2 stay steady. Without the macro, field 1 stays steady.
